// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer:
// state encoding, the four supported opcodes, ALU operation codes and
// the opcode class produced by mc_opcode_class.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_RTYPE = 2'd0,
    CLS_LD    = 2'd1,
    CLS_SD    = 2'd2,
    CLS_BEQ   = 2'd3
  } op_class_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Every return to FETCH is an instruction boundary where a pending
  // stop request parks the sequencer in IDLE instead.
  function automatic state_t boundaryNext(input logic stopReq);
    return stopReq ? ST_IDLE : ST_FETCH;
  endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Purely combinational opcode classifier: maps inst[6:0] onto one of the
// four supported instruction classes and flags anything else as illegal.
module mc_opcode_class
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class,
  output logic       o_legal
);

  // Decode the opcode; unknown encodings fall back to R-type with legal low
  always_comb begin
    o_class = CLS_RTYPE;
    o_legal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin o_class = CLS_RTYPE; o_legal = 1'b1; end
      OP_LD:    begin o_class = CLS_LD;    o_legal = 1'b1; end
      OP_SD:    begin o_class = CLS_SD;    o_legal = 1'b1; end
      OP_BEQ:   begin o_class = CLS_BEQ;   o_legal = 1'b1; end
      default:  begin o_class = CLS_RTYPE; o_legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB).
// Control outputs are decoded from the registered state and the current
// inputs only. Defining PERF_CNT_EN adds the instr_retired and
// stall_cycles performance counters and their ports.
module mc_sequencer
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       illegal,
  output logic [2:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] instr_retired,
  output logic [31:0] stall_cycles
`endif
);

  state_t    r_state;
  state_t    w_next;
  op_class_t w_class;
  logic      w_legal;
  logic      r_illegal;

  mc_opcode_class u_class (
    .i_opcode (opcode),
    .o_class  (w_class),
    .o_legal  (w_legal)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Sticky illegal flag: set by a bad opcode in DECODE, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n)                         r_illegal <= 1'b0;
    else if (r_state == ST_IDLE && start) r_illegal <= 1'b0;
    else if (r_state == ST_DECODE && !w_legal) r_illegal <= 1'b1;
  end

  // Next-state and control decode from current state, opcode class and inputs
  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = ALU_ADD;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next = w_legal ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        case (w_class)
          CLS_RTYPE: begin
            alu_op = ALU_FUNCT;
            w_next = ST_WB;
          end
          CLS_LD, CLS_SD: begin
            alu_src = 1'b1;
            w_next  = ST_MEM;
          end
          CLS_BEQ: begin
            alu_op = ALU_SUB;
            if (branch_taken) begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
            w_next = boundaryNext(stop);
          end
          default: w_next = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        alu_src = 1'b1;
        if (w_class == CLS_SD) mem_write = 1'b1;
        else                   mem_read  = 1'b1;
        if (mem_ready) w_next = (w_class == CLS_SD) ? boundaryNext(stop) : ST_WB;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (w_class == CLS_LD);
        w_next     = boundaryNext(stop);
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy    = (r_state != ST_IDLE);
  assign illegal = r_illegal;
  assign state   = r_state;

`ifdef PERF_CNT_EN
  logic [31:0] r_instrRetired;
  logic [31:0] r_stallCycles;
  logic        w_retire;
  logic        w_stall;

  assign w_retire = (r_state == ST_WB) ||
                    (r_state == ST_EXEC && w_class == CLS_BEQ) ||
                    (r_state == ST_MEM && w_class == CLS_SD && mem_ready);
  assign w_stall  = (r_state == ST_FETCH || r_state == ST_MEM) && !mem_ready;

  // Free-running wrap-around counters for retired instructions and memory stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instrRetired <= 32'd0;
      r_stallCycles  <= 32'd0;
    end else begin
      if (w_retire) r_instrRetired <= r_instrRetired + 32'd1;
      if (w_stall)  r_stallCycles  <= r_stallCycles + 32'd1;
    end
  end

  assign instr_retired = r_instrRetired;
  assign stall_cycles  = r_stallCycles;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer. The stimulus side walks each
// instruction through its phases as described behaviourally (fetch with
// N wait cycles, decode, execute, optional memory with M waits, write-back)
// and queues the expected outputs for every cycle; a monitor pops and
// compares on each falling edge. Counter ports are checked when
// PERF_CNT_EN is defined.
module tb_mc_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5;
  localparam logic [6:0] C_R = 7'b0110011, C_LD = 7'b0000011,
                         C_SD = 7'b0100011, C_BEQ = 7'b1100011;

  typedef struct {
    logic [14:0] ctrl;
    logic [31:0] ret;
    logic [31:0] stl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, stop, mem_ready, branch_taken;
  logic [6:0] opcode;
  logic pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic [1:0] alu_op;
  logic busy, illegal;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] instr_retired, stall_cycles;
`endif

  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic mIllegal = 1'b0;
  logic [31:0] mRetired = 32'd0;
  logic [31:0] mStall = 32'd0;

  mc_sequencer dut (
    .clk (clk), .rst_n (rst_n), .start (start), .stop (stop),
    .opcode (opcode), .mem_ready (mem_ready), .branch_taken (branch_taken),
    .pc_write (pc_write), .pc_src (pc_src), .ir_write (ir_write),
    .mem_read (mem_read), .mem_write (mem_write), .mem_to_reg (mem_to_reg),
    .alu_src (alu_src), .reg_write (reg_write), .alu_op (alu_op),
    .busy (busy), .illegal (illegal), .state (state)
`ifdef PERF_CNT_EN
    , .instr_retired (instr_retired), .stall_cycles (stall_cycles)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Build one expected record from the model's current sticky and counter values
  function automatic exp_t mk(input logic [2:0] s, input logic pcw, pcs, irw, mr, mw,
                              m2r, as, rw, input logic [1:0] aop);
    exp_t e;
    e.ctrl = {s, pcw, pcs, irw, mr, mw, m2r, as, rw, aop, (s != S_IDLE), mIllegal};
    e.ret  = mRetired;
    e.stl  = mStall;
    return e;
  endfunction

  // Drive one cycle of inputs, queue its expectation and advance to the next cycle
  task automatic applyStimulus(input logic st, stp, mr, bt, rn, input exp_t e);
    start = st; stop = stp; mem_ready = mr; branch_taken = bt; rst_n = rn;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Compare the DUT outputs of the current cycle with one expected record
  task automatic checkOutput(input exp_t e);
    logic [14:0] got;
    got = {state, pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg,
           alu_src, reg_write, alu_op, busy, illegal};
    compared++;
    if (got !== e.ctrl) begin
      mismatched++;
      $display("[TB] FAIL ctrl cyc%0d got st=%0d vec=%b want st=%0d vec=%b",
               cyc, got[14:12], got[11:0], e.ctrl[14:12], e.ctrl[11:0]);
    end
`ifdef PERF_CNT_EN
    compared++;
    if (instr_retired !== e.ret || stall_cycles !== e.stl) begin
      mismatched++;
      $display("[TB] FAIL counters cyc%0d got ret=%0d stall=%0d want ret=%0d stall=%0d",
               cyc, instr_retired, stall_cycles, e.ret, e.stl);
    end
`endif
  endtask

  // Monitor: pop and compare the expected record for every cycle that has one
  always @(negedge clk) begin
    cyc++;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One IDLE cycle; an accepted start clears the sticky illegal flag
  task automatic idleCycle(input logic st, stp);
    applyStimulus(st, stp, rnd(), rnd(), 1'b1, mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    if (st) mIllegal = 1'b0;
  endtask

  // Run one instruction starting in FETCH; toIdle reports where it ends
  task automatic runInstr(input logic [6:0] opc, input int fw, input int mw,
                          input logic bt, input logic stp, input int rstAt,
                          output bit toIdle);
    logic isLd, isSd, isBeq, legal, rdy;
    isLd  = (opc == C_LD);
    isSd  = (opc == C_SD);
    isBeq = (opc == C_BEQ);
    legal = (opc == C_R) || isLd || isSd || isBeq;
    toIdle = 1'b0;
    opcode = opc;
    for (int k = 0; k <= fw; k++) begin
      rdy = (k == fw);
      applyStimulus(rnd(), stp, rdy, rnd(), 1'b1, mk(S_FETCH, rdy, 0, rdy, 1, 0, 0, 0, 0, 2'b00));
      if (!rdy) mStall++;
    end
    applyStimulus(rnd(), stp, rnd(), rnd(), 1'b1, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    if (!legal) begin
      mIllegal = 1'b1;
      toIdle = 1'b1;
      return;
    end
    if (isBeq) begin
      applyStimulus(rnd(), stp, rnd(), bt, 1'b1, mk(S_EXEC, bt, bt, 0, 0, 0, 0, 0, 0, 2'b01));
      mRetired++;
      toIdle = stp;
      return;
    end
    if (isLd || isSd) begin
      applyStimulus(rnd(), stp, rnd(), rnd(), 1'b1, mk(S_EXEC, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00));
      for (int k = 0; k <= mw; k++) begin
        rdy = (k == mw);
        if (k == rstAt) begin
          applyStimulus(rnd(), stp, 1'b0, rnd(), 1'b0,
                        mk(S_MEM, 0, 0, 0, isLd, isSd, 0, 1, 0, 2'b00));
          mIllegal = 1'b0;
          mRetired = 32'd0;
          mStall   = 32'd0;
          toIdle   = 1'b1;
          return;
        end
        applyStimulus(rnd(), stp, rdy, rnd(), 1'b1, mk(S_MEM, 0, 0, 0, isLd, isSd, 0, 1, 0, 2'b00));
        if (!rdy) mStall++;
      end
      if (isSd) begin
        mRetired++;
        toIdle = stp;
        return;
      end
    end else begin
      applyStimulus(rnd(), stp, rnd(), rnd(), 1'b1, mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10));
    end
    applyStimulus(rnd(), stp, rnd(), rnd(), 1'b1, mk(S_WB, 0, 0, 0, 0, 0, isLd, 0, 1, 2'b00));
    mRetired++;
    toIdle = stp;
  endtask

  // Directed scenarios followed by a randomized instruction stream
  initial begin
    bit t;
    logic [6:0] opc;
    int r;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
    branch_taken = 1'b0; opcode = C_R;
    repeat (3) @(posedge clk);
    #1;

    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b1);
    idleCycle(1'b1, 1'b0);
    runInstr(C_R,   0, 0, 1'b0, 1'b0, -1, t);
    runInstr(C_LD,  0, 3, 1'b0, 1'b0, -1, t);
    runInstr(C_BEQ, 0, 0, 1'b1, 1'b0, -1, t);
    runInstr(C_BEQ, 1, 0, 1'b0, 1'b0, -1, t);
    runInstr(C_SD,  0, 2, 1'b0, 1'b1, -1, t);
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b1);
    idleCycle(1'b1, 1'b0);
    runInstr(7'b1111111, 0, 0, 1'b0, 1'b0, -1, t);
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b1, 1'b0);

    t = 1'b0;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    opc = C_R;
        2, 3:    opc = C_LD;
        4, 5:    opc = C_SD;
        6, 7:    opc = C_BEQ;
        8:       opc = 7'b0010011;
        default: opc = 7'($urandom_range(0, 127));
      endcase
      runInstr(opc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd(),
               ($urandom_range(0, 5) == 0), -1, t);
      if (t) begin
        repeat ($urandom_range(0, 2)) idleCycle(1'b0, rnd());
        idleCycle(1'b1, rnd());
        t = 1'b0;
      end
    end

    runInstr(C_SD, 0, 3, 1'b0, 1'b0, 1, t);
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b0, 1'b0);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  leave IDLE and begin fetching.
REQ-004 SHALL have port: stop  input  1  halt request, honoured at the next instruction boundary.
REQ-005 SHALL have port: opcode  input  7  inst[6:0] of the current instruction register.
REQ-006 SHALL have port: mem_ready  input  1  memory access completes this cycle.
REQ-007 SHALL have port: branch_taken  input  1  ALU zero flag, valid in EXEC.
REQ-008 SHALL have ports (outputs, 1 bit each): pc_write, pc_src (0 = pc+4, 1 = branch target), ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write.
REQ-009 SHALL have port: alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
REQ-010 SHALL have ports: busy  output  1  state != IDLE; illegal  output  1  sticky illegal-opcode flag; state  output  3  current state.

Function
REQ-011 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB.
REQ-012 IDLE SHALL drive all control outputs to 0 and SHALL go to FETCH when start=1; start SHALL be ignored in all other states.
REQ-013 FETCH SHALL drive mem_read=1 and hold it until mem_ready=1. In that cycle it SHALL pulse ir_write=1 and pc_write=1 with pc_src=0, then go to DECODE.
REQ-014 DECODE SHALL last one cycle. Legal opcodes are 0110011, 0000011, 0100011 and 1100011; any legal opcode SHALL go to EXEC. Any other opcode SHALL set illegal=1 and go to IDLE.
REQ-015 EXEC SHALL drive alu_src and alu_op per opcode: R-type 0/10, ld 1/00, sd 1/00, beq 0/01.
REQ-016 EXEC transitions: R-type goes to WB; ld and sd go to MEM; beq goes to FETCH and drives pc_write=pc_src=1 only when branch_taken=1.
REQ-017 MEM SHALL hold mem_read=1 (ld) or mem_write=1 (sd), keeping alu_src=1 and alu_op=00, until mem_ready=1. Then ld goes to WB and sd goes to FETCH.
REQ-018 WB SHALL drive reg_write=1 for exactly one cycle, with mem_to_reg=1 for ld and 0 for R-type, then go to FETCH.
REQ-019 Every transition into FETCH is an instruction boundary. If stop=1 at a boundary, the block SHALL go to IDLE instead of FETCH; stop in IDLE has no effect.
REQ-020 Cycle counts with zero-wait memory (mem_ready=1): R-type 4, ld 5, sd 4, beq 3. Each wait cycle SHALL add one cycle.
REQ-021 pc_write, ir_write and reg_write SHALL never be asserted for more than one cycle per instruction.
REQ-022 illegal SHALL clear only on reset or on a start accepted in IDLE.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force IDLE and drive illegal=0, busy=0, all control outputs 0 and state=0. This SHALL apply in any state, including mid-MEM, where the access is abandoned.
REQ-024 Control outputs SHALL be decoded from registered state and the current inputs only; no output SHALL depend combinationally on rst_n.

Configuration
REQ-025 With PERF_CNT_EN defined, the block SHALL add outputs instr_retired[31:0] and stall_cycles[31:0], both 0 on reset and wrapping modulo 2^32.
REQ-026 instr_retired SHALL increment on: leaving WB, sd completing MEM, and beq leaving EXEC. Illegal opcodes SHALL NOT count.
REQ-027 stall_cycles SHALL increment on each cycle spent in FETCH or MEM with mem_ready=0.
REQ-028 Without PERF_CNT_EN, neither the counter ports nor the counter logic SHALL exist; all other behaviour is identical.

Structure
REQ-029 Shared package riscv_ctrl_pkg SHALL hold the state enum, the opcode constants (OP_RTYPE, OP_LD, OP_SD, OP_BEQ) and the alu_op encodings.
REQ-030 Opcode classification (class and legal flag) SHALL be one combinational sub-module, mc_opcode_class; the FSM and counters stay in mc_sequencer.

Verification
REQ-031 Reset, then start, mem_ready=1, opcode=0110011: states FETCH, DECODE, EXEC, WB, FETCH; reg_write=1 only in WB; alu_op=10.
REQ-032 opcode=0000011, mem_ready low for 3 cycles in MEM: mem_read held 4 cycles; WB has mem_to_reg=1; stall_cycles +3 (PERF_CNT_EN defined).
REQ-033 opcode=1100011: with branch_taken=1, pc_write=pc_src=1 in EXEC; with branch_taken=0, no pc_write in EXEC; 3 cycles each.
REQ-034 opcode=1111111: illegal=1 after DECODE, state IDLE, busy=0; a new start clears illegal.
REQ-035 stop=1 during an sd MEM wait: the store completes, then IDLE; no further FETCH; instr_retired +1.
REQ-036 rst_n=0 for one cycle mid-MEM with mem_write=1: next cycle IDLE, all outputs 0, counters 0.
